regfile_2r1w_sb: RTL

//  Next-generation CPU register file: 2 async read ports, 1 sync write port, optional hardwired-zero R0.

---
 rtl/regfile_2r1w_sb.sv | 87 ++++++++
 1 files changed

// File: rtl/regfile_2r1w_sb.sv
// Register file with two combinational read ports, one synchronous write port,
// optional hardwired-zero R0, write->read bypass and a busy scoreboard for RAW/WAW stalls.
module regfile_2r1w_sb #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 8,
  parameter int R0_ZERO  = 0,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_a_en,
  input  logic [AW-1:0]       rd_a_addr,
  output logic [DATA_W-1:0]   rd_a_data,
  input  logic                rd_b_en,
  input  logic [AW-1:0]       rd_b_addr,
  output logic [DATA_W-1:0]   rd_b_data,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                issue_en,
  input  logic [AW-1:0]       issue_addr,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam logic [AW:0] NREGS = (AW+1)'(NUM_REGS);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  logic wr_ok, hit_a, hit_b, hit_i;
  logic busy_a, busy_b, waw, issue_ok;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < NREGS;
  endfunction

  // Out-of-range indices and a hardwired R0 behave identically: read 0, never busy, never written.
  function automatic logic usable(input logic [AW-1:0] a);
    return in_range(a) && !((R0_ZERO != 0) && (a == '0));
  endfunction

  always_comb begin
    wr_ok = wr_en && usable(wr_addr);
    hit_a = (BYPASS != 0) && wr_ok && (wr_addr == rd_a_addr);
    hit_b = (BYPASS != 0) && wr_ok && (wr_addr == rd_b_addr);
    hit_i = (BYPASS != 0) && wr_ok && (wr_addr == issue_addr);

    rd_a_data = '0;
    if (usable(rd_a_addr))
      rd_a_data = hit_a ? wr_data : regs[rd_a_addr];
    rd_b_data = '0;
    if (usable(rd_b_addr))
      rd_b_data = hit_b ? wr_data : regs[rd_b_addr];

    busy_a = usable(rd_a_addr) && busy[rd_a_addr] && !hit_a;
    busy_b = usable(rd_b_addr) && busy[rd_b_addr] && !hit_b;
    waw    = issue_en && usable(issue_addr) && busy[issue_addr] && !hit_i;

    stall    = (rd_a_en && busy_a) || (rd_b_en && busy_b) || waw;
    issue_ok = issue_en && !stall && usable(issue_addr);

    // Set after clear so a same-edge issue to the written register stays pending.
    busy_next = busy;
    if (wr_ok)
      busy_next[wr_addr] = 1'b0;
    if (issue_ok)
      busy_next[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok)
        regs[wr_addr] <= wr_data;
      busy <= busy_next;
    end
  end

  assign busy_vec = busy;

endmodule
